// File: rtl/shifter_right_seq.sv
// Multi-cycle right shifter for the ALU: one bit per clock under a start/done handshake.
// Define SHIFTER_RIGHT_SRA_EN to accept the arithmetic (sign-filling) function code.
module shifter_right_seq #(
  parameter logic [5:0] SRL = 6'b000010,
  parameter logic [5:0] SRA = 6'b000011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [5:0]  Signal,
  output logic        busy,
  output logic        done,
  output logic [31:0] dataOut
);

`ifdef SHIFTER_RIGHT_SRA_EN
  localparam bit SraEnabled = 1'b1;
`else
  localparam bit SraEnabled = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } stateT;

  stateT       state, nextState;
  logic [31:0] result, nextResult;
  logic [4:0]  count, nextCount;
  logic        fill, nextFill;
  logic        isSrl, isSra, legal, accept;

  // Fill bit is latched at acceptance so the operand inputs are free afterwards.
  always_comb begin
    nextState  = state;
    nextResult = result;
    nextCount  = count;
    nextFill   = fill;
    isSrl      = (Signal == SRL);
    isSra      = (Signal == SRA);
    legal      = (isSrl || (SraEnabled && isSra)) && (dataB[31:5] == 27'd0);
    accept     = start && (state != SHIFT);

    case (state)
      SHIFT: begin
        nextResult = {fill, result[31:1]};
        nextCount  = count - 5'd1;
        if (count == 5'd1) begin
          nextState = DONE;
        end
      end
      default: begin
        if (accept) begin
          if (!legal) begin
            nextResult = 32'd0;
            nextCount  = 5'd0;
            nextFill   = 1'b0;
            nextState  = DONE;
          end else if (dataB[4:0] == 5'd0) begin
            nextResult = dataA;
            nextCount  = 5'd0;
            nextFill   = 1'b0;
            nextState  = DONE;
          end else begin
            nextResult = dataA;
            nextCount  = dataB[4:0];
            nextFill   = isSra & dataA[31];
            nextState  = SHIFT;
          end
        end else if (state == DONE) begin
          nextState = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      result <= 32'd0;
      count  <= 5'd0;
      fill   <= 1'b0;
    end else begin
      state  <= nextState;
      result <= nextResult;
      count  <= nextCount;
      fill   <= nextFill;
    end
  end

  assign busy    = (state == SHIFT);
  assign done    = (state == DONE);
  assign dataOut = result;

endmodule

// File: tb/tb_shifter_right_seq.sv
// Self-checking bench for shifter_right_seq: fixed vectors, hand-written corner sequences
// and randomized requests checked against an arithmetic reference model.
module tb_shifter_right_seq;

  localparam logic [5:0] SRL = 6'b000010;
  localparam logic [5:0] SRA = 6'b000011;

`ifdef SHIFTER_RIGHT_SRA_EN
  localparam bit SraEn = 1'b1;
`else
  localparam bit SraEn = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  sig;
    logic [31:0] expOut;
    int          expLat;
  } TestVector;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  Signal;
  logic        busy;
  logic        done;
  logic [31:0] dataOut;

  int checkCount = 0;
  int errorCount = 0;
  int injectAt   = -1;

  TestVector vecs[7];

  shifter_right_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .dataA   (dataA),
    .dataB   (dataB),
    .Signal  (Signal),
    .busy    (busy),
    .done    (done),
    .dataOut (dataOut)
  );

  always #5 clk = ~clk;

  // Expected result and done latency (cycles after acceptance) from the operation's definition.
  function automatic logic [31:0] refModel(input logic [31:0] a, input logic [31:0] b,
                                           input logic [5:0] sig, output int lat);
    logic signed [31:0] sa;
    lat = 0;
    if (!((sig == SRL) || (SraEn && sig == SRA)) || b > 32'd31) return 32'd0;
    lat = int'(b);
    sa  = a;
    if (sig == SRA) return sa >>> b;
    return a >> b;
  endfunction

  task automatic checkOutput(input string what, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", what, act, exp);
    end
  endtask

  // Called at a negedge; request is accepted at the following posedge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [5:0] sig);
    dataA  = a;
    dataB  = b;
    Signal = sig;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    dataA  = $urandom;
    dataB  = $urandom;
    Signal = 6'($urandom);
  endtask

  task automatic waitDone(input int expLat, output int lat);
    lat = -1;
    for (int idx = 0; idx < 64; idx++) begin
      @(negedge clk);
      checkOutput("busy", {31'd0, busy}, {31'd0, (idx < expLat)});
      checkOutput("busyDoneExclusive", {31'd0, busy & done}, 32'd0);
      start = 1'b0;
      if (idx == injectAt) begin
        start  = 1'b1;
        dataA  = 32'hFFFF_FFFF;
        dataB  = 32'd1;
        Signal = SRL;
      end
      if (done) begin
        lat   = idx;
        start = 1'b0;
        break;
      end
    end
    if (lat < 0) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL doneTimeout: got no done expected done after %0d cycles", expLat);
    end
  endtask

  task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic [5:0] sig,
                       input logic [31:0] expOut, input int expLat, input bit idleAfter,
                       input string tag);
    int lat;
    applyStimulus(a, b, sig);
    waitDone(expLat, lat);
    checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, " dataOut"}, dataOut, expOut);
    if (idleAfter) begin
      @(negedge clk);
      checkOutput({tag, " donePulse"}, {31'd0, done}, 32'd0);
      checkOutput({tag, " hold"}, dataOut, expOut);
    end
  endtask

  initial begin
    int lat;
    logic [31:0] a, b, exp;
    logic [5:0] sig;
    bit sawDone;

    vecs[0] = '{32'h8000_0001, 32'd4,         SRL,     32'h0800_0000, 4};
    vecs[1] = '{32'h1234_5678, 32'd0,         SRL,     32'h1234_5678, 0};
    vecs[2] = '{32'h8000_0000, 32'd31,        SRL,     32'h0000_0001, 31};
    vecs[3] = '{32'hDEAD_BEEF, 32'd32,        SRL,     32'h0000_0000, 0};
    vecs[4] = '{32'hDEAD_BEEF, 32'd3,         6'b0,    32'h0000_0000, 0};
    vecs[5] = '{32'hCAFE_0000, 32'h0001_0003, SRL,     32'h0000_0000, 0};
`ifdef SHIFTER_RIGHT_SRA_EN
    vecs[6] = '{32'h8000_0000, 32'd4,         SRA,     32'hF800_0000, 4};
`else
    vecs[6] = '{32'h8000_0000, 32'd4,         SRA,     32'h0000_0000, 0};
`endif

    rst    = 1'b1;
    start  = 1'b0;
    dataA  = 32'd0;
    dataB  = 32'd0;
    Signal = 6'd0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset dataOut", dataOut, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      runOp(vecs[i].a, vecs[i].b, vecs[i].sig, vecs[i].expOut, vecs[i].expLat, 1'b1,
            $sformatf("vec%0d", i));
    end

    // Start while shifting must be ignored.
    injectAt = 2;
    runOp(32'h0000_FF00, 32'd8, SRL, 32'h0000_00FF, 8, 1'b1, "startInShift");
    injectAt = -1;

    // Back-to-back: second request issued in the DONE cycle of the first.
    runOp(32'h0000_0F00, 32'd8, SRL, 32'h0000_000F, 8, 1'b0, "b2bFirst");
    runOp(32'h0000_00F0, 32'd4, SRL, 32'h0000_000F, 4, 1'b1, "b2bSecond");

    // Reset mid-shift aborts without a done pulse.
    applyStimulus(32'hFFFF_FFFF, 32'd20, SRL);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    checkOutput("abort done", {31'd0, done}, 32'd0);
    checkOutput("abort dataOut", dataOut, 32'd0);
    sawDone = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    checkOutput("abort noDone", {31'd0, sawDone}, 32'd0);

    for (int n = 0; n < 40; n++) begin
      int kind, sk;
      a    = $urandom;
      kind = $urandom_range(0, 9);
      if (kind < 7)       b = 32'($urandom_range(0, 31));
      else if (kind == 7) b = $urandom;
      else if (kind == 8) b = 32'd0;
      else                b = 32'd31;
      sk = $urandom_range(0, 5);
      if (sk < 3)       sig = SRL;
      else if (sk < 5)  sig = SRA;
      else              sig = 6'($urandom);
      exp = refModel(a, b, sig, lat);
      runOp(a, b, sig, exp, lat, 1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/shifter_right_seq.md
Name: shifter_right_seq

Overview:
- Multi-cycle logical right shifter for the ALU datapath; the right-shift counterpart of the combinational left shifter (SLL).
- Accepts an operand and shift amount under a start/done handshake and shifts one bit per clock.
- The ALU top muxes dataOut by function code, exactly as for the SLL path.
- Same operand/function-code port shape as the left shifter, so it drops into the ALU select tree unchanged.

Parameters:
- SRL, 6'b000010, function code for logical right shift.
- SRA, 6'b000011, function code for arithmetic right shift; used only when the optional feature is enabled.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- dataA  input  32  operand to shift.
- dataB  input  32  shift amount; only [4:0] is used when [31:5]==0.
- Signal  input  6  function code.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when dataOut becomes valid.
- dataOut  output  32  result; held stable from done until the next accepted start.

Behaviour:
- Reset: one clock; synchronous, active-high reset (rst). State returns to IDLE, busy=0, done=0, dataOut=0, shift counter=0.
- Reset dominates start in the same cycle. Reset during SHIFT aborts the operation; no done pulse.
- States are IDLE, SHIFT and DONE.
- IDLE: busy=0, done=0, dataOut holds its last value. A start that is not accepted is ignored.
- Accept on start=1 in IDLE or DONE, at edge E0. On acceptance, operands are captured into internal registers and the inputs are don't-care afterwards.
- Illegal request: Signal is not a supported code, or dataB[31:5]!=0. The result register is loaded with 0 and the next state is DONE.
- Zero shift, N=dataB[4:0]=0: the result register is loaded with dataA and the next state is DONE.
- Otherwise: the result register is loaded with dataA, the counter with N, and the next state is SHIFT.
- SHIFT, each edge:
  - result <= {fill, result[31:1]}; fill is 0 for SRL.
  - counter decrements by 1.
  - When the counter goes from 1 to 0, the next state is DONE. Otherwise the state stays SHIFT.
  - start is ignored in SHIFT.
- DONE: lasts exactly one cycle with done=1 and busy=0.
  - With start=1, a new request is accepted (back-to-back) and the state goes to SHIFT or DONE per the rules above.
  - With start=0, the next state is IDLE.
- Latency: done is high in the cycle after edge E0+max(N,0). N=0 gives done after E0; N=31 gives done after E0+31. Throughput is one operation per N+1 cycles.
- dataOut is driven directly from the result register, which only changes on acceptance and in SHIFT. dataOut is valid during and after done.
- busy and done are never high together.

Optional Feature:
- Macro: SHIFTER_RIGHT_SRA_EN.
- Defined: Signal==SRA is a supported code. Fill is the captured dataA[31], so sign extension is preserved for every N. Timing is identical to SRL.
- Not defined: SRA is an illegal request and gives dataOut=0 with done after E0.

Test Plan:
- Reset mid-shift: start SRL with dataA=32'hFFFF_FFFF, dataB=20; assert rst at the 5th cycle. Expect busy=0, done=0, dataOut=0 next cycle and no done pulse afterwards.
- Basic SRL: dataA=32'h8000_0001, dataB=4, Signal=SRL. Expect busy for 4 cycles, done in the 5th cycle after start, dataOut=32'h0800_0000.
- Boundary amounts:
  - dataB=0 gives dataOut=dataA, with done the cycle after start.
  - dataB=31 with dataA=32'h8000_0000 gives dataOut=1, with done 31 cycles after E0.
- Illegal requests:
  - dataB=32 gives dataOut=0 and done the cycle after start.
  - Signal=6'b000000 gives dataOut=0.
  - A start during SHIFT is ignored and the result is unchanged.
- Back-to-back: assert start with a new request (dataA=32'h0000_00F0, dataB=4) in the DONE cycle. Expect no IDLE cycle, busy the next cycle, then dataOut=32'h0000_000F.
- With SHIFTER_RIGHT_SRA_EN: dataA=32'h8000_0000, dataB=4, Signal=SRA gives dataOut=32'hF800_0000. Without the macro, the same request gives 0.
